// File: rtl/control_unit.sv
// control_unit -- hardwired control sequencer for the Mini-SRC processor.
//
// Every instruction runs a three-state fetch (T0-T2), then an opcode-specific
// execute sequence (T3 onward), then returns to T0. All control outputs are
// decoded combinationally from the current state and the opcode IR[31:27].
//
// Optional feature macro: CU_STOP_EN
//   When defined, Stop is sampled on every edge that would enter T0. If it is
//   high, the sequencer parks in STOPPED, with all outputs low, until Stop drops.
//   When undefined, Stop is ignored and STOPPED does not exist.
//
// Ports:
//   clock, clear      rising-edge clock; asynchronous active-high reset
//   IR[31:0]          latched instruction word (opcode in [31:27])
//   CON               branch-condition flag
//   Stop              pause request (CU_STOP_EN builds only)
//   *out              bus-drive selects (never more than one active)
//   *in               register load enables
//   Gra/Grb/Grc       register-field selects
//   IncPC/Read/Write  ALU PC+1 mode, memory read, memory write
//   alu_op[4:0]       operation presented to the ALU
//   Run               high while sequencing instructions

module control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        LOout,
    output logic        HIout,
    output logic        MDRout,
    output logic        InPortout,
    output logic        Cout,
    output logic        BAout,
    output logic        Rout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        Zhighin,
    output logic        Zlowin,
    output logic        Rin,
    output logic        CONin,
    output logic        OutPortin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_op,
    output logic        Run
);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_MFHI = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RESET,
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7,
        S_HALT
`ifdef CU_STOP_EN
        , S_STOPPED
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] op;

    assign op = IR[31:27];

`ifdef CU_STOP_EN
    logic unused_bits;
    assign unused_bits = ^IR[26:0];
`else
    logic unused_bits;
    assign unused_bits = ^{IR[26:0], Stop};
`endif

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state_q <= S_RESET;
        else       state_q <= state_d;
    end

    // Next state: each execute state ends the instruction for the opcodes
    // whose sequence is that long; everything else advances one step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2: begin
                if (op == OP_HALT)      state_d = S_HALT;
                else if (op == OP_NOP || op[4:2] == 3'b111) state_d = S_T0;
                else                    state_d = S_T3;
            end
            S_T3: begin
                case (op) inside
                    OP_JR, OP_IN, OP_OUT, OP_MFLO, OP_MFHI: state_d = S_T0;
                    default:                                state_d = S_T4;
                endcase
            end
            S_T4: begin
                case (op) inside
                    OP_JAL, OP_NEG, OP_NOT: state_d = S_T0;
                    default:                state_d = S_T5;
                endcase
            end
            S_T5: begin
                case (op) inside
                    OP_LDI, [OP_ADD:OP_ORI]: state_d = S_T0;
                    default:                 state_d = S_T6;
                endcase
            end
            S_T6: begin
                case (op) inside
                    OP_DIV, OP_MUL, OP_BR: state_d = S_T0;
                    default:               state_d = S_T7;
                endcase
            end
            S_T7:    state_d = S_T0;
            S_HALT:  state_d = S_HALT;
`ifdef CU_STOP_EN
            S_STOPPED: state_d = S_T0;
`endif
            default: state_d = S_RESET;
        endcase
`ifdef CU_STOP_EN
        // Any transition into T0 (including from STOPPED) is diverted while
        // Stop is held, so a pause never interrupts an instruction.
        if (state_d == S_T0 && Stop) state_d = S_STOPPED;
`endif
    end

    always_comb begin
        PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; LOout = 1'b0;
        HIout = 1'b0; MDRout = 1'b0; InPortout = 1'b0; Cout = 1'b0;
        BAout = 1'b0; Rout = 1'b0;
        PCin = 1'b0; MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
        HIin = 1'b0; LOin = 1'b0; Zhighin = 1'b0; Zlowin = 1'b0; Rin = 1'b0;
        CONin = 1'b0; OutPortin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
        alu_op = '0;
        Run = 1'b0;

        case (state_q)
            S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
                Run = 1'b1;
                case (op) inside
                    OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_BR: alu_op = OP_ADD;
                    OP_ANDI: alu_op = 5'b00101;
                    OP_ORI:  alu_op = 5'b00110;
                    default: alu_op = op;
                endcase
            end
            default: ;
        endcase

        case (state_q)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                case (op) inside
                    OP_LD, OP_LDI, OP_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    [OP_ADD:OP_ORI]:      begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    OP_DIV, OP_MUL:       begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    OP_NEG, OP_NOT:       begin Grb = 1'b1; Rout = 1'b1; Zlowin = 1'b1; end
                    OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    OP_JAL:  begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                    OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                    OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (op) inside
                    [OP_ADD:OP_SHL]: begin Grc = 1'b1; Rout = 1'b1; Zlowin = 1'b1; end
                    OP_LD, OP_LDI, OP_ST, [OP_ADDI:OP_ORI]: begin Cout = 1'b1; Zlowin = 1'b1; end
                    OP_DIV, OP_MUL: begin
                        Grb = 1'b1; Rout = 1'b1; Zhighin = 1'b1; Zlowin = 1'b1;
                    end
                    OP_NEG, OP_NOT: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_BR:   begin PCout = 1'b1; Yin = 1'b1; end
                    OP_JAL:  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (op) inside
                    OP_LDI, [OP_ADD:OP_ORI]: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_LD, OP_ST:   begin Zlowout = 1'b1; MARin = 1'b1; end
                    OP_DIV, OP_MUL: begin Zlowout = 1'b1; LOin = 1'b1; end
                    OP_BR:          begin Cout = 1'b1; Zlowin = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (op) inside
                    OP_LD:          begin Read = 1'b1; MDRin = 1'b1; end
                    OP_ST:          begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    OP_DIV, OP_MUL: begin Zhighout = 1'b1; HIin = 1'b1; end
                    OP_BR: begin
                        if (CON) begin Zlowout = 1'b1; PCin = 1'b1; end
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (op) inside
                    OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_ST:   Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit. Expected control words come from a
// table of per-step signal-name lists for each opcode; the bus-drive
// exclusivity rule is monitored on every cycle.
module tb_control_unit;

    logic        clock, clear, CON, Stop;
    logic [31:0] IR;
    logic PCout, Zhighout, Zlowout, LOout, HIout, MDRout, InPortout, Cout, BAout, Rout;
    logic PCin, MARin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, Rin, CONin, OutPortin;
    logic Gra, Grb, Grc, IncPC, Read, Write, Run;
    logic [4:0] alu_op;

    int unsigned errors = 0;
    int unsigned checks = 0;

    string names [28];
    string exp_q [$];

    logic [27:0] ctl;
    assign ctl = {PCout, Zhighout, Zlowout, LOout, HIout, MDRout, InPortout, Cout, BAout, Rout,
                  PCin, MARin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, Rin, CONin, OutPortin,
                  Gra, Grb, Grc, IncPC, Read, Write};

    control_unit dut (
        .clock(clock), .clear(clear), .IR(IR), .CON(CON), .Stop(Stop),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .LOout(LOout), .HIout(HIout),
        .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
        .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin),
        .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin), .Rin(Rin), .CONin(CONin),
        .OutPortin(OutPortin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC),
        .Read(Read), .Write(Write), .alu_op(alu_op), .Run(Run)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam string FETCH0 = "PCout MARin IncPC Zlowin";

    function automatic logic [27:0] mask_of(input string s);
        logic [27:0] m;
        string tok;
        m = '0;
        tok = "";
        for (int i = 0; i <= s.len(); i++) begin
            if (i == s.len() || s.getc(i) == 8'h20) begin
                for (int n = 0; n < 28; n++)
                    if (tok.len() != 0 && names[n] == tok) m[27-n] = 1'b1;
                tok = "";
            end else begin
                tok = {tok, s.substr(i, i)};
            end
        end
        return m;
    endfunction

    function automatic logic [4:0] exp_alu(input logic [4:0] op);
        case (op)
            5'd0, 5'd1, 5'd2, 5'd12, 5'd19: return 5'd3;
            5'd13: return 5'd5;
            5'd14: return 5'd6;
            default: return op;
        endcase
    endfunction

    // Per-step control lists for one instruction, fetch included.
    function automatic void fill_seq(input logic [4:0] op, input bit con);
        exp_q.delete();
        exp_q.push_back(FETCH0);
        exp_q.push_back("Zlowout PCin Read MDRin");
        exp_q.push_back("MDRout IRin");
        if (op >= 5'd3 && op <= 5'd11) begin
            exp_q.push_back("Grb Rout Yin"); exp_q.push_back("Grc Rout Zlowin");
            exp_q.push_back("Zlowout Gra Rin");
        end else if (op >= 5'd12 && op <= 5'd14) begin
            exp_q.push_back("Grb Rout Yin"); exp_q.push_back("Cout Zlowin");
            exp_q.push_back("Zlowout Gra Rin");
        end else begin
            case (op)
                5'd1: begin
                    exp_q.push_back("Grb BAout Yin"); exp_q.push_back("Cout Zlowin");
                    exp_q.push_back("Zlowout Gra Rin");
                end
                5'd0, 5'd2: begin
                    exp_q.push_back("Grb BAout Yin"); exp_q.push_back("Cout Zlowin");
                    exp_q.push_back("Zlowout MARin");
                    if (op == 5'd0) begin
                        exp_q.push_back("Read MDRin"); exp_q.push_back("MDRout Gra Rin");
                    end else begin
                        exp_q.push_back("Gra Rout MDRin"); exp_q.push_back("Write");
                    end
                end
                5'd15, 5'd16: begin
                    exp_q.push_back("Gra Rout Yin"); exp_q.push_back("Grb Rout Zhighin Zlowin");
                    exp_q.push_back("Zlowout LOin"); exp_q.push_back("Zhighout HIin");
                end
                5'd17, 5'd18: begin
                    exp_q.push_back("Grb Rout Zlowin"); exp_q.push_back("Zlowout Gra Rin");
                end
                5'd19: begin
                    exp_q.push_back("Gra Rout CONin"); exp_q.push_back("PCout Yin");
                    exp_q.push_back("Cout Zlowin");
                    exp_q.push_back(con ? "Zlowout PCin" : "");
                end
                5'd20: exp_q.push_back("Gra Rout PCin");
                5'd21: begin
                    exp_q.push_back("PCout Grb Rin"); exp_q.push_back("Gra Rout PCin");
                end
                5'd22: exp_q.push_back("InPortout Gra Rin");
                5'd23: exp_q.push_back("Gra Rout OutPortin");
                5'd24: exp_q.push_back("LOout Gra Rin");
                5'd25: exp_q.push_back("HIout Gra Rin");
                default: ;
            endcase
        end
    endfunction

    always @(negedge clock) begin
        checks++;
        if (!$onehot0(ctl[27:18])) begin
            errors++;
            $display("FAIL bus_exclusive t=%0t: drives=%b required at most one", $time, ctl[27:18]);
        end
    end

    task automatic test_reset();
        clear = 1'b1; IR = '0; CON = 1'b0; Stop = 1'b0;
        #1;
        checks++;
        if (ctl !== '0 || Run !== 1'b0 || alu_op !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs: ctl=%h Run=%b alu_op=%b required 0/0/0", ctl, Run, alu_op);
        end
        @(posedge clock); @(negedge clock);
        checks++;
        if (ctl !== '0 || Run !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: ctl=%h Run=%b required 0/0", ctl, Run);
        end
        clear = 1'b0;
        @(posedge clock); @(negedge clock);
        checks++;
        if (ctl !== mask_of(FETCH0) || Run !== 1'b1) begin
            errors++;
            $display("FAIL reset_to_T0: ctl=%h Run=%b required %h/1", ctl, Run, mask_of(FETCH0));
        end
    endtask

    // Entered and left at a falling edge while the DUT is in T0.
    task automatic test_sequence(input logic [31:0] ir, input bit con);
        logic [4:0] op;
        op = ir[31:27];
        fill_seq(op, con);
        IR = ir; CON = con;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) begin @(posedge clock); @(negedge clock); end
            checks++;
            if (ctl !== mask_of(exp_q[k])) begin
                errors++;
                $display("FAIL seq_ctl op=%b step=T%0d: ctl=%h required %h", op, k, ctl, mask_of(exp_q[k]));
            end
            checks++;
            if (Run !== 1'b1) begin
                errors++;
                $display("FAIL seq_run op=%b step=T%0d: Run=%b required 1", op, k, Run);
            end
            if (k >= 3) begin
                checks++;
                if (alu_op !== exp_alu(op)) begin
                    errors++;
                    $display("FAIL seq_alu op=%b step=T%0d: alu_op=%b required %b", op, k, alu_op, exp_alu(op));
                end
            end
        end
        @(posedge clock); @(negedge clock);
        checks++;
        if (ctl !== mask_of(FETCH0)) begin
            errors++;
            $display("FAIL seq_return op=%b after %0d cycles: ctl=%h required %h", op, exp_q.size(), ctl, mask_of(FETCH0));
        end
    endtask

    task automatic test_directed();
        test_sequence(32'h18918000, 1'b0);           // add R1,R2,R3
        test_sequence({5'b00000, 27'h0123456}, 1'b0); // ld
        test_sequence({5'b00010, 27'h0654321}, 1'b1); // st
        test_sequence({5'b10011, 27'h0000010}, 1'b1); // br taken
        test_sequence({5'b10011, 27'h0000010}, 1'b0); // br not taken
        test_sequence({5'b10000, 27'h0}, 1'b0);       // mul
        test_sequence({5'b10101, 27'h0}, 1'b0);       // jal
        test_sequence({5'b11010, 27'h0}, 1'b0);       // nop
        test_sequence({5'b11111, 27'h0}, 1'b0);       // unused code
    endtask

    task automatic test_random();
        logic [4:0] op;
        for (int n = 0; n < 60; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd3;
`ifndef CU_STOP_EN
            Stop = 1'($urandom);
`endif
            test_sequence({op, 27'($urandom)}, 1'($urandom));
        end
        Stop = 1'b0;
    endtask

    task automatic test_clear_mid();
        IR = {5'b10000, 27'h0};
        repeat (4) @(posedge clock);
        @(negedge clock);
        checks++;
        if (ctl !== mask_of("Grb Rout Zhighin Zlowin")) begin
            errors++;
            $display("FAIL mul_T4: ctl=%h required %h", ctl, mask_of("Grb Rout Zhighin Zlowin"));
        end
        #1 clear = 1'b1;
        #1;
        checks++;
        if (ctl !== '0 || Run !== 1'b0 || alu_op !== 5'd0) begin
            errors++;
            $display("FAIL clear_async: ctl=%h Run=%b alu_op=%b required 0/0/0", ctl, Run, alu_op);
        end
        @(negedge clock) clear = 1'b0;
        @(posedge clock); @(negedge clock);
        checks++;
        if (ctl !== mask_of(FETCH0) || Run !== 1'b1) begin
            errors++;
            $display("FAIL clear_restart: ctl=%h Run=%b required %h/1", ctl, Run, mask_of(FETCH0));
        end
    endtask

    task automatic test_halt();
        IR = {5'b11011, 27'h0};
        @(posedge clock); @(negedge clock);
        @(posedge clock); @(negedge clock);
        checks++;
        if (ctl !== mask_of("MDRout IRin") || Run !== 1'b1) begin
            errors++;
            $display("FAIL halt_T2: ctl=%h Run=%b required %h/1", ctl, Run, mask_of("MDRout IRin"));
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clock); @(negedge clock);
            checks++;
            if (ctl !== '0 || Run !== 1'b0) begin
                errors++;
                $display("FAIL halt_hold cycle %0d: ctl=%h Run=%b required 0/0", c, ctl, Run);
            end
        end
        clear = 1'b1;
        @(negedge clock) clear = 1'b0;
        @(posedge clock); @(negedge clock);
        checks++;
        if (ctl !== mask_of(FETCH0) || Run !== 1'b1) begin
            errors++;
            $display("FAIL halt_restart: ctl=%h Run=%b required %h/1", ctl, Run, mask_of(FETCH0));
        end
    endtask

`ifdef CU_STOP_EN
    task automatic test_stop();
        IR = 32'h18918000;
        repeat (5) @(posedge clock);
        @(negedge clock);
        checks++;
        if (ctl !== mask_of("Zlowout Gra Rin")) begin
            errors++;
            $display("FAIL stop_T5: ctl=%h required %h", ctl, mask_of("Zlowout Gra Rin"));
        end
        Stop = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); @(negedge clock);
            checks++;
            if (ctl !== '0 || Run !== 1'b0) begin
                errors++;
                $display("FAIL stopped cycle %0d: ctl=%h Run=%b required 0/0", c, ctl, Run);
            end
        end
        Stop = 1'b0;
        @(posedge clock); @(negedge clock);
        checks++;
        if (ctl !== mask_of(FETCH0) || Run !== 1'b1) begin
            errors++;
            $display("FAIL stop_resume: ctl=%h Run=%b required %h/1", ctl, Run, mask_of(FETCH0));
        end
    endtask
`endif

    initial begin
        names = '{"PCout", "Zhighout", "Zlowout", "LOout", "HIout", "MDRout", "InPortout",
                  "Cout", "BAout", "Rout", "PCin", "MARin", "MDRin", "IRin", "Yin", "HIin",
                  "LOin", "Zhighin", "Zlowin", "Rin", "CONin", "OutPortin", "Gra", "Grb",
                  "Grc", "IncPC", "Read", "Write"};
        test_reset();
        test_directed();
        test_random();
        test_clear_mid();
        test_halt();
`ifdef CU_STOP_EN
        test_stop();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
